// File: rtl/dtmf_pcm_pkg.sv
// Shared constants and receive-FSM encoding for the PCM/u-law datapath.
package dtmf_pcm_pkg;

    localparam logic [7:0]  ULAW_IDLE = 8'hFF;
    localparam int unsigned PCM_BITS  = 8;
    localparam int unsigned BIT_CNT_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/pcm_rx_fifo.sv
// Byte FIFO between the PCM deserializer and the u-law expander.
// The head byte is registered and reads ULAW_IDLE whenever the FIFO is empty.
module pcm_rx_fifo
    import dtmf_pcm_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [PCM_BITS-1:0]      wdata,
    input  logic                     pop,
    output logic [PCM_BITS-1:0]      rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [PCM_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    logic                pop_ok_c;
    logic                push_ok_c;
    logic [AW-1:0]       rd_n_c;
    logic [AW-1:0]       wr_n_c;
    logic [LW-1:0]       level_n_c;
    logic [PCM_BITS-1:0] head_n_c;

    // Accept/pop qualification, next pointers/level and next head byte.
    always_comb begin
        pop_ok_c  = pop & ~empty;
        push_ok_c = push & (~full | pop_ok_c);
        rd_n_c    = pop_ok_c  ? rd_ptr + AW'(1) : rd_ptr;
        wr_n_c    = push_ok_c ? wr_ptr + AW'(1) : wr_ptr;
        level_n_c = level + LW'(push_ok_c) - LW'(pop_ok_c);
        head_n_c  = ULAW_IDLE;
        if (level_n_c != '0) begin
            // A write into the slot that becomes the head bypasses the array.
            head_n_c = (push_ok_c && (wr_ptr == rd_n_c)) ? wdata : mem[rd_n_c];
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers, level, status flags and registered head byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
            rdata  <= ULAW_IDLE;
        end else begin
            wr_ptr <= wr_n_c;
            rd_ptr <= rd_n_c;
            level  <= level_n_c;
            empty  <= (level_n_c == '0);
            full   <= (level_n_c == LW'(DEPTH));
            rdata  <= head_n_c;
        end
    end

endmodule

// File: rtl/pcm_serial_rx.sv
// Serial u-law PCM receiver: synchronizes the external bit clock, deserializes
// MSB-first bytes framed by pcm_fs and buffers them for the u-law expander.
module pcm_serial_rx
    import dtmf_pcm_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pcm_sclk,
    input  logic                          pcm_fs,
    input  logic                          pcm_din,
    output logic [7:0]                    upcm,
    output logic                          upcm_valid,
    input  logic                          upcm_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clr_err
);

    logic sclk_s1, sclk_s2, sclk_d;
    logic fs_s1, fs_s2;
    logic din_s1, din_s2;
    logic sclk_rise_c;

    rx_state_t               state, state_n;
    logic [BIT_CNT_W-1:0]    bit_cnt;
    logic [PCM_BITS-2:0]     shift_q;

    logic load_c, shift_c, push_c, ferr_set_c, ovf_set_c, pop_c;
    logic fifo_full, fifo_empty;

    // Two-flop synchronizers plus a delayed sclk copy for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_s1 <= 1'b0; sclk_s2 <= 1'b0; sclk_d <= 1'b0;
            fs_s1   <= 1'b0; fs_s2   <= 1'b0;
            din_s1  <= 1'b0; din_s2  <= 1'b0;
        end else begin
            sclk_s1 <= pcm_sclk; sclk_s2 <= sclk_s1; sclk_d <= sclk_s2;
            fs_s1   <= pcm_fs;   fs_s2   <= fs_s1;
            din_s1  <= pcm_din;  din_s2  <= din_s1;
        end
    end

    assign sclk_rise_c = sclk_s2 & ~sclk_d;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // FSM next state: frame sync always (re)starts a byte.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (sclk_rise_c && fs_s2) state_n = SHIFT;
            end
            SHIFT: begin
                if (sclk_rise_c && !fs_s2 && bit_cnt == BIT_CNT_W'(PCM_BITS - 1)) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // FSM outputs: datapath load/shift/push strobes and frame error detect.
    always_comb begin
        load_c     = 1'b0;
        shift_c    = 1'b0;
        push_c     = 1'b0;
        ferr_set_c = 1'b0;
        case (state)
            IDLE: begin
                if (sclk_rise_c && fs_s2) load_c = 1'b1;
            end
            SHIFT: begin
                if (sclk_rise_c) begin
                    if (fs_s2) begin
                        load_c     = 1'b1;
                        ferr_set_c = 1'b1;
                    end else if (bit_cnt == BIT_CNT_W'(PCM_BITS - 1)) begin
                        push_c = 1'b1;
                    end else begin
                        shift_c = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Shift register and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (load_c) begin
            shift_q <= {(PCM_BITS - 2)'(0), din_s2};
            bit_cnt <= BIT_CNT_W'(1);
        end else if (shift_c) begin
            shift_q <= {shift_q[PCM_BITS-3:0], din_s2};
            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
        end else if (push_c) begin
            bit_cnt <= '0;
        end
    end

    assign pop_c     = upcm_valid & upcm_ready;
    assign ovf_set_c = push_c & fifo_full & ~pop_c;

    // Sticky error flags; clear wins over a same-cycle set.
    always_ff @(posedge clk) begin
        if (reset || clr_err) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (ovf_set_c)  overflow  <= 1'b1;
            if (ferr_set_c) frame_err <= 1'b1;
        end
    end

    pcm_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_c),
        .wdata ({shift_q, din_s2}),
        .pop   (upcm_ready),
        .rdata (upcm),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign upcm_valid = ~fifo_empty;

endmodule

// File: tb/tb_pcm_serial_rx.sv
// Self-checking bench for pcm_serial_rx: queue-based reference model plus
// directed scenarios with literal expectations and a randomized phase.
module tb_pcm_serial_rx;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pcm_sclk = 1'b0;
    logic       pcm_fs = 1'b0;
    logic       pcm_din = 1'b0;
    logic [7:0] upcm;
    logic       upcm_valid;
    logic       upcm_ready = 1'b0;
    logic [2:0] fifo_level;
    logic       overflow;
    logic       frame_err;
    logic       clr_err = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;
    bit rnd_mode = 1'b0;

    pcm_serial_rx #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pcm_sclk   (pcm_sclk),
        .pcm_fs     (pcm_fs),
        .pcm_din    (pcm_din),
        .upcm       (upcm),
        .upcm_valid (upcm_valid),
        .upcm_ready (upcm_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Input samples seen at the last four clk edges; a bit clock rise takes
    // effect three edges after it first appears at the pins.
    bit         h_sclk [4];
    bit         h_fs   [4];
    bit         h_din  [4];
    int         m_cnt;
    int         m_byte;
    logic [7:0] m_q [$];
    bit         m_ovf, m_ferr;

    always @(posedge clk) begin
        bit act, a_fs, a_din, pop, wr, ovf_set, ferr_set;
        logic [7:0] wb;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                h_sclk[i] = 0; h_fs[i] = 0; h_din[i] = 0;
            end
            m_cnt = 0; m_byte = 0; m_q.delete(); m_ovf = 0; m_ferr = 0;
        end else begin
            for (int i = 3; i > 0; i--) begin
                h_sclk[i] = h_sclk[i-1]; h_fs[i] = h_fs[i-1]; h_din[i] = h_din[i-1];
            end
            h_sclk[0] = pcm_sclk; h_fs[0] = pcm_fs; h_din[0] = pcm_din;
            act   = h_sclk[2] && !h_sclk[3];
            a_fs  = h_fs[2];
            a_din = h_din[2];
            pop   = upcm_ready && (m_q.size() > 0);
            wr = 0; ferr_set = 0; wb = 8'h00;
            if (act) begin
                if (a_fs) begin
                    if (m_cnt > 0) ferr_set = 1;
                    m_byte = int'(a_din);
                    m_cnt  = 1;
                end else if (m_cnt > 0) begin
                    m_byte = m_byte * 2 + int'(a_din);
                    m_cnt++;
                    if (m_cnt == 8) begin
                        wr = 1; wb = 8'(m_byte); m_cnt = 0;
                    end
                end
            end
            ovf_set = wr && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (wr && !ovf_set) m_q.push_back(wb);
            if (ovf_set)  m_ovf = 1;
            if (ferr_set) m_ferr = 1;
            if (clr_err) begin m_ovf = 0; m_ferr = 0; end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", 32'(upcm_valid), 32'(m_q.size() > 0));
            chk("model_upcm",  32'(upcm), (m_q.size() > 0) ? 32'(m_q[0]) : 32'hFF);
            chk("model_level", 32'(fifo_level), 32'(m_q.size()));
            chk("model_ovf",   32'(overflow), 32'(m_ovf));
            chk("model_ferr",  32'(frame_err), 32'(m_ferr));
        end
    end

    // Record of every byte the consumer accepted.
    logic [7:0] popped [$];
    always @(posedge clk) begin
        if (!reset && upcm_valid && upcm_ready) popped.push_back(upcm);
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            upcm_ready = 1'($urandom_range(0, 1));
            clr_err    = ($urandom_range(0, 39) == 0);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_bit(input bit f, input bit d, input int hi, input int lo);
        pcm_fs  = f;
        pcm_din = d;
        ticks(lo);
        pcm_sclk = 1'b1;
        ticks(hi);
        pcm_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
        for (int i = 7; i >= 0; i--) send_bit(i == 7, b[i], hi, lo);
        pcm_fs = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int base;
        logic [7:0] b;
        logic [7:0] exp4 [5];

        do_reset();
        chk_en = 1'b1;
        chk("rst_valid", 32'(upcm_valid), 32'h0);
        chk("rst_upcm",  32'(upcm), 32'hFF);
        chk("rst_level", 32'(fifo_level), 32'h0);
        chk("rst_flags", 32'({overflow, frame_err}), 32'h0);

        // Single byte A5, latency of final bit.
        upcm_ready = 1'b1;
        b = 8'hA5;
        for (int i = 7; i >= 1; i--) send_bit(i == 7, b[i], 2, 2);
        pcm_fs = 1'b0; pcm_din = b[0];
        ticks(2);
        pcm_sclk = 1'b1;
        tick(); chk("lat_e1_valid", 32'(upcm_valid), 32'h0);
        tick(); chk("lat_e2_valid", 32'(upcm_valid), 32'h0);
        tick(); chk("lat_e3_valid", 32'(upcm_valid), 32'h1);
                chk("lat_e3_upcm",  32'(upcm), 32'hA5);
        pcm_sclk = 1'b0;
        tick(); chk("a5_pulse_end", 32'(upcm_valid), 32'h0);
                chk("a5_idle_code", 32'(upcm), 32'hFF);

        // Overflow with 5 bytes into depth 4, frame error, then clr_err.
        do_reset();
        upcm_ready = 1'b0;
        for (int k = 1; k <= 5; k++) send_byte(8'(k), 2, 2);
        ticks(4);
        chk("ovf_level", 32'(fifo_level), 32'd4);
        chk("ovf_flag",  32'(overflow), 32'h1);
        chk("ovf_ferr0", 32'(frame_err), 32'h0);
        send_bit(1, 0, 2, 2); send_bit(0, 1, 2, 2); send_bit(0, 1, 2, 2);
        send_byte(8'hC3, 2, 2);
        ticks(4);
        chk("ferr_set",   32'(frame_err), 32'h1);
        chk("ovf_still",  32'(overflow), 32'h1);
        chk("full_level", 32'(fifo_level), 32'd4);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_flags", 32'({overflow, frame_err}), 32'h0);
        chk("clr_level", 32'(fifo_level), 32'd4);
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_read", 32'(upcm), 32'(k));
            upcm_ready = 1'b1;
            tick();
            upcm_ready = 1'b0;
        end
        chk("ovf_drained", 32'(upcm_valid), 32'h0);

        // Frame sync after 5 bits of 3C, then full 7E.
        do_reset();
        upcm_ready = 1'b1;
        base = popped.size();
        send_bit(1, 0, 2, 2); send_bit(0, 0, 2, 2); send_bit(0, 1, 2, 2);
        send_bit(0, 1, 2, 2); send_bit(0, 1, 2, 2);
        send_byte(8'h7E, 2, 2);
        ticks(6);
        chk("fs_ferr",  32'(frame_err), 32'h1);
        chk("fs_count", 32'(popped.size() - base), 32'd1);
        if (popped.size() > base) chk("fs_byte", 32'(popped[base]), 32'h7E);

        // Full FIFO, pop aligned with the write of the next byte.
        do_reset();
        upcm_ready = 1'b0;
        for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k), 3, 2);
        ticks(4);
        chk("al_full", 32'(fifo_level), 32'd4);
        base = popped.size();
        b = 8'h14;
        for (int i = 7; i >= 1; i--) send_bit(i == 7, b[i], 2, 2);
        pcm_fs = 1'b0; pcm_din = b[0];
        ticks(2);
        pcm_sclk = 1'b1;
        tick(); tick();
        upcm_ready = 1'b1;
        tick();
        upcm_ready = 1'b0;
        pcm_sclk = 1'b0;
        chk("al_level", 32'(fifo_level), 32'd4);
        chk("al_ovf",   32'(overflow), 32'h0);
        chk("al_head",  32'(upcm), 32'h11);
        upcm_ready = 1'b1;
        ticks(6);
        upcm_ready = 1'b0;
        exp4 = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        chk("al_count", 32'(popped.size() - base), 32'd5);
        for (int k = 0; k < 5; k++)
            if (popped.size() > base + k) chk("al_order", 32'(popped[base + k]), 32'(exp4[k]));

        // Reset mid-byte, stray bits without fs, then 55.
        do_reset();
        upcm_ready = 1'b1;
        send_bit(1, 1, 2, 2); send_bit(0, 0, 2, 2); send_bit(0, 1, 2, 2); send_bit(0, 0, 2, 2);
        do_reset();
        chk("mid_rst_level", 32'(fifo_level), 32'h0);
        base = popped.size();
        send_bit(0, 1, 2, 2); send_bit(0, 1, 2, 2); send_bit(0, 1, 2, 2);
        send_byte(8'h55, 2, 2);
        ticks(6);
        chk("mr_count", 32'(popped.size() - base), 32'd1);
        if (popped.size() > base) chk("mr_byte", 32'(popped[base]), 32'h55);
        chk("mr_flags", 32'({overflow, frame_err}), 32'h0);

        // Randomized traffic against the model.
        do_reset();
        rnd_mode = 1'b1;
        for (int n = 0; n < 40; n++) begin
            int hi, lo;
            hi = $urandom_range(2, 4);
            lo = $urandom_range(2, 4);
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = $urandom_range(0, 6);
                send_bit(1, 1'($urandom_range(0, 1)), hi, lo);
                for (int j = 0; j < k; j++) send_bit(0, 1'($urandom_range(0, 1)), hi, lo);
            end
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                send_bit(0, 1'($urandom_range(0, 1)), hi, lo);
            send_byte(8'($urandom_range(0, 255)), hi, lo);
        end
        rnd_mode = 1'b0;
        clr_err = 1'b0;
        upcm_ready = 1'b1;
        ticks(20);
        chk("rnd_drained", 32'(upcm_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pcm_serial_rx.md
PCM_SERIAL_RX -- requirements
Module: pcm_serial_rx

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of received u-law bytes buffered; legal values are powers of two, 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic SHALL be rising-edge clk.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port pcm_sclk, input, 1 bit: external serial PCM bit clock, asynchronous to clk.
REQ-005 The block SHALL have port pcm_fs, input, 1 bit: frame sync; it is high during the bit period of the first (MSB) bit.
REQ-006 The block SHALL have port pcm_din, input, 1 bit: serial u-law data, MSB first, valid on the rising edge of pcm_sclk.
REQ-007 The block SHALL have port upcm, output, 8 bits: the u-law byte at the FIFO head, consumed by the u-law expander.
REQ-008 The block SHALL have port upcm_valid, output, 1 bit: high when upcm holds an unread byte.
REQ-009 The block SHALL have port upcm_ready, input, 1 bit: consumer accept; a byte pops on a clk edge where upcm_valid and upcm_ready are both high.
REQ-010 The block SHALL have port fifo_level, output, log2(FIFO_DEPTH)+1 bits: the current byte count.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag for a byte dropped because the FIFO was full.
REQ-012 The block SHALL have port frame_err, output, 1 bit: sticky flag for a frame sync arriving mid-byte.
REQ-013 The block SHALL have port clr_err, input, 1 bit: synchronous clear of overflow and frame_err.

Function
REQ-014 pcm_sclk, pcm_fs and pcm_din SHALL each pass through a 2-flop synchronizer; a rising sclk edge is detected as sync_sclk high while its delayed copy is low.
REQ-015 pcm_sclk high and low times are each at least 2 clk periods; the block is not required to handle faster input.
REQ-016 The FSM SHALL have two states: IDLE and SHIFT.
REQ-017 IDLE: on a detected edge with sync fs=1, the block SHALL load the sync din as bit 7, set the bit count to 1 and go to SHIFT. Edges with fs=0 SHALL be ignored.
REQ-018 SHIFT: each detected edge SHALL shift in the sync din and increment the count.
REQ-019 On the 8th bit, the block SHALL write {shift[6:0], din} into the FIFO on that same clk edge, then return to IDLE.
REQ-020 SHIFT: a detected edge with fs=1 before bit 8 SHALL discard the partial byte, set frame_err and restart with this bit as bit 7 (count=1).
REQ-021 Latency: upcm_valid SHALL rise 3 clk edges after the pcm_sclk rising edge carrying bit 0 first appears at the input, when the FIFO is empty.
REQ-022 Write to a full FIFO with no pop in the same cycle: the byte SHALL be dropped, overflow SHALL be set, and FIFO contents SHALL be unchanged.
REQ-023 Write and pop in the same cycle while full: the write SHALL be accepted, fifo_level SHALL be unchanged and overflow SHALL not be set.
REQ-024 Write and pop in the same cycle while empty: the write SHALL be accepted with no pop, and level becomes 1.
REQ-025 When upcm_valid is low, upcm SHALL output 8'hFF (u-law idle code).
REQ-026 upcm SHALL remain stable while upcm_valid=1 and upcm_ready=0.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 clr_err has priority over a same-cycle set event: the flags SHALL read 0 on the next cycle.

Reset
REQ-029 On reset: the FSM SHALL be IDLE, the bit count 0, the shift register 0, the synchronizers 0, the FIFO pointers and fifo_level 0, upcm_valid 0, upcm 8'hFF, and overflow and frame_err 0.
REQ-030 Reset asserted mid-byte SHALL discard the partial byte and all buffered bytes; after release, the block SHALL require a new fs before accepting data.

Structure
REQ-031 Shared package dtmf_pcm_pkg SHALL hold ULAW_IDLE=8'hFF, PCM_BITS=8 and the rx state encoding (IDLE, SHIFT).
REQ-032 The FIFO SHALL be a sub-module pcm_rx_fifo (parameterized depth, 8-bit data, push/pop/full/empty/level); the deserializer FSM SHALL stay in pcm_serial_rx.

Verification
REQ-033 Scenario: after reset, send byte 8'hA5 with fs on bit 7 and upcm_ready=1 -> upcm_valid pulses 1 cycle with upcm=8'hA5, upcm returns to 8'hFF, and the latency matches REQ-021.
REQ-034 Scenario: upcm_ready=0, send 5 bytes 8'h01..8'h05 with FIFO_DEPTH=4 -> fifo_level=4, overflow=1, and subsequent reads return 01, 02, 03, 04.
REQ-035 Scenario: fs after 5 bits of byte 8'h3C, then full byte 8'h7E -> frame_err=1, exactly one byte 8'h7E delivered.
REQ-036 Scenario: FIFO full with upcm_ready=1 aligned to the 8th edge of the next byte -> no overflow, level stays 4, and order is preserved.
REQ-037 Scenario: reset asserted after bit 4 of a byte, then a full byte 8'h55 with fs -> only 8'h55 is delivered, and flags are 0.
REQ-038 Scenario: clr_err pulsed while overflow=1 and frame_err=1 -> both read 0 the next cycle, and FIFO contents are unaffected.
